branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer that sits beside the direction predictor in fetch. It consumes the predictor's taken/not-taken bit `pcsrcPF` and turns it into a concrete next-fetch PC. It carries its own prediction down to M alongside the pipeline and checks it against the resolved branch. It then raises a redirect with the correct fetch PC and updates its table from M-stage branch results.

## Interface
Parameters:
- `BTB_DEPTH`, 4: index bits; table holds 2^BTB_DEPTH entries.
- `TAG_WIDTH`, 8: stored tag bits; `BTB_DEPTH + TAG_WIDTH` must be ≤ 30.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pcF`  in  32  fetch PC (word aligned).
- `pcsrcPF`  in  1  direction prediction from the predictor for `pcF`.
- `stallD`  in  1  hold the F→D pipeline register.
- `flushE`  in  1  clear the D→E pipeline register.
- `branchM`  in  1  M-stage instruction is a branch.
- `pcM`  in  32  M-stage PC.
- `pcsrcM`  in  1  resolved direction.
- `btaM`  in  32  resolved branch target.
- `hitF`  out  1  valid tag match for `pcF`.
- `takenPF`  out  1  effective prediction = `pcsrcPF & hitF`.
- `npcF`  out  32  predicted next PC.
- `mispM`  out  1  M-stage redirect required.
- `fpcM`  out  32  correct fetch PC on redirect.

## Operation
- Index = `pc[BTB_DEPTH+1:2]`.
- Tag = `pc[BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2]`.
- Each entry holds valid (1), tag (`TAG_WIDTH`) and target (30, word address).
- Lookup (combinational):
  - `hitF` = valid & tag match.
  - `npcF` = `takenPF ? {target,2'b00} : pcF+4`.
  - `pcF+4` wraps modulo 2^32.
- A taken prediction without a BTB hit degrades to not-taken. The effective prediction is `takenPF`, not `pcsrcPF`.
- Pipeline: `takenPF` and the predicted target travel F→D→E→M in three register stages.
  - F→D holds when `stallD`.
  - D→E clears to 0 when `flushE`.
  - E→M is always enabled.
- Check in M, only when `branchM`:
  - `mispM` = `(pcsrcM != takenPM) | (pcsrcM & takenPM & (targetPM != btaM[31:2]))`.
  - `mispM` = 0 when `branchM` = 0.
- `fpcM` = `pcsrcM ? btaM : pcM+4`. It is only meaningful when `mispM` = 1.
- Update, when `branchM & pcsrcM`: write valid=1, tag(`pcM`), `btaM[31:2]` at index(`pcM`), overwriting any prior occupant.
- A not-taken branch leaves the table unchanged.
- Non-branches never write.

## Timing
- Lookup has zero latency: `hitF`, `takenPF` and `npcF` follow `pcF`/`pcsrcPF` in the same cycle.
- Prediction reaches M three edges after F, plus any `stallD` cycles. `mispM`/`fpcM` are combinational in M.
- Table write takes effect on the edge ending the M cycle.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update contents (see Configuration).
- `stallD` and `flushE` asserted together: the F→D register holds and the D→E register clears.
- Reset values:
  - All valid bits = 0.
  - All pipeline registers = 0.
  - Hence after reset `hitF`=0, `takenPF`=0, `npcF`=`pcF+4`, `mispM`=0.
- Reset asserted mid-operation takes priority over any concurrent update or stall on that edge.
- Tag and target arrays need no reset.

## Configuration
- `BTB_BYPASS_EN` defined: a same-cycle update whose index and tag match `pcF` is forwarded to the lookup. `hitF`=1 and the target = `btaM[31:2]` in that cycle.
- `BTB_BYPASS_EN` undefined: no forwarding. The lookup returns the old contents and the new entry is visible from the next cycle.

## Test plan
- Reset, then `pcF`=0x00400000, `pcsrcPF`=1 → `hitF`=0, `takenPF`=0, `npcF`=0x00400004.
- Taken branch `pcM`=0x00400010, `btaM`=0x00400100, `branchM`=1, `pcsrcM`=1, not in table → `mispM`=1, `fpcM`=0x00400100. Next cycle, `pcF`=0x00400010 with `pcsrcPF`=1 → `hitF`=1, `npcF`=0x00400100.
- Entry from the previous case, same branch resolved not-taken at M with `takenPM`=1 → `mispM`=1, `fpcM`=0x00400014. The entry is still present afterwards.
- Same index, different tag: `pcM`=0x00400410 (`BTB_DEPTH`=4, `TAG_WIDTH`=8) taken to 0x00400800 → entry replaced; `pcF`=0x00400010 then gives `hitF`=0.
- Predicted taken to 0x00400100, resolved taken to 0x00400200 → `mispM`=1, `fpcM`=0x00400200. `flushE` in the D cycle instead → `takenPM`=0 and `mispM` follows `pcsrcM` only.
- Same-cycle update and lookup of 0x00400020: `hitF`=1 with `BTB_BYPASS_EN`, `hitF`=0 without, `hitF`=1 on the following cycle in both builds. `pcF`=0xFFFFFFFC miss → `npcF`=0x00000000.

Source files
------------

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB turning a direction bit into a next-fetch PC
// Optional macro BTB_BYPASS_EN forwards a same-cycle M-stage update into the fetch lookup.
module branch_target_buffer #(
  parameter int BTB_DEPTH = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        pcsrcPF,
  input  logic        stallD,
  input  logic        flushE,
  input  logic        branchM,
  input  logic [31:0] pcM,
  input  logic        pcsrcM,
  input  logic [31:0] btaM,
  output logic        hitF,
  output logic        takenPF,
  output logic [31:0] npcF,
  output logic        mispM,
  output logic [31:0] fpcM
);
  localparam int Entries = 1 << BTB_DEPTH;

  logic [Entries-1:0]   validQ;
  logic [TAG_WIDTH-1:0] tagQ    [Entries];
  logic [29:0]          targetQ [Entries];

  logic [BTB_DEPTH-1:0] idxF, idxM;
  logic [TAG_WIDTH-1:0] tagF, tagM;
  logic                 writeM;
  logic                 hitRaw;
  logic [29:0]          targetF;

  assign idxF   = pcF[BTB_DEPTH+1:2];
  assign idxM   = pcM[BTB_DEPTH+1:2];
  assign tagF   = pcF[BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2];
  assign tagM   = pcM[BTB_DEPTH+TAG_WIDTH+1:BTB_DEPTH+2];
  assign writeM = branchM & pcsrcM;
  assign hitRaw = validQ[idxF] && (tagQ[idxF] == tagF);

`ifdef BTB_BYPASS_EN
  logic bypass;
  assign bypass  = writeM && (idxM == idxF) && (tagM == tagF);
  assign hitF    = hitRaw | bypass;
  assign targetF = bypass ? btaM[31:2] : targetQ[idxF];
`else
  assign hitF    = hitRaw;
  assign targetF = targetQ[idxF];
`endif

  // A predicted-taken fetch with no entry has nowhere to go, so it falls through.
  assign takenPF = pcsrcPF & hitF;
  assign npcF    = takenPF ? {targetF, 2'b00} : pcF + 32'd4;

  logic        takenPD, takenPE, takenPM;
  logic [29:0] targetPD, targetPE, targetPM;

  always_ff @(posedge clk) begin
    if (rst) begin
      takenPD  <= 1'b0;
      targetPD <= '0;
      takenPE  <= 1'b0;
      targetPE <= '0;
      takenPM  <= 1'b0;
      targetPM <= '0;
    end else begin
      if (!stallD) begin
        takenPD  <= takenPF;
        targetPD <= targetF;
      end
      if (flushE) begin
        takenPE  <= 1'b0;
        targetPE <= '0;
      end else begin
        takenPE  <= takenPD;
        targetPE <= targetPD;
      end
      takenPM  <= takenPE;
      targetPM <= targetPE;
    end
  end

  assign mispM = branchM & ((pcsrcM != takenPM) |
                            (pcsrcM & takenPM & (targetPM != btaM[31:2])));
  assign fpcM  = pcsrcM ? btaM : pcM + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= '0;
    end else if (writeM) begin
      validQ[idxM] <= 1'b1;
    end
  end

  // Tag/target need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (!rst && writeM) begin
      tagQ[idxM]    <= tagM;
      targetQ[idxM] <= btaM[31:2];
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer against a table/pipeline model
module tb_branch_target_buffer;
  localparam int Depth = 4;
  localparam int Tw    = 8;
  localparam int N     = 1 << Depth;

  logic        clk = 1'b0;
  logic        rst, pcsrcPF, stallD, flushE, branchM, pcsrcM;
  logic [31:0] pcF, pcM, btaM;
  logic        hitF, takenPF, mispM;
  logic [31:0] npcF, fpcM;

  branch_target_buffer #(.BTB_DEPTH(Depth), .TAG_WIDTH(Tw)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .pcsrcPF(pcsrcPF), .stallD(stallD),
    .flushE(flushE), .branchM(branchM), .pcM(pcM), .pcsrcM(pcsrcM), .btaM(btaM),
    .hitF(hitF), .takenPF(takenPF), .npcF(npcF), .mispM(mispM), .fpcM(fpcM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        tk;
    logic [31:0] npc;
    logic        misp;
    logic [31:0] fpc;
  } expT;

  expT expQ[$];
  int  total  = 0;
  int  passed = 0;

  // Reference state: table indexed by word address modulo N, plus the three in-flight predictions.
  bit          mValid [N];
  int unsigned mTag   [N];
  logic [29:0] mTgt   [N];
  bit          pTk    [3];
  logic [29:0] pTgt   [3];

  function automatic int unsigned idxOf(input logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return (pc / (4 * N)) % (1 << Tw);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      check("hitF", {31'd0, hitF}, {31'd0, e.hit});
      check("takenPF", {31'd0, takenPF}, {31'd0, e.tk});
      check("npcF", npcF, e.npc);
      check("mispM", {31'd0, mispM}, {31'd0, e.misp});
      if (e.misp) check("fpcM", fpcM, e.fpc);
    end
  end

  task automatic cyc(input bit r, input logic [31:0] pf, input bit pp, input bit st,
                     input bit fl, input bit bm, input logic [31:0] pm, input bit ps,
                     input logic [31:0] bta, input bit chk);
    expT         e;
    int unsigned i;
    bit          hit;
    logic [29:0] tgt;
    rst = r; pcF = pf; pcsrcPF = pp; stallD = st; flushE = fl;
    branchM = bm; pcM = pm; pcsrcM = ps; btaM = bta;
    i   = idxOf(pf);
    hit = mValid[i] && (mTag[i] == tagOf(pf));
    tgt = mTgt[i];
`ifdef BTB_BYPASS_EN
    if (bm && ps && idxOf(pm) == i && tagOf(pm) == tagOf(pf)) begin
      hit = 1'b1;
      tgt = bta[31:2];
    end
`endif
    e.hit  = hit;
    e.tk   = pp && hit;
    e.npc  = e.tk ? {tgt, 2'b00} : pf + 32'd4;
    e.misp = bm && ((ps != pTk[2]) || (ps && pTk[2] && pTgt[2] != bta[31:2]));
    e.fpc  = ps ? bta : pm + 32'd4;
    if (chk) expQ.push_back(e);
    if (r) begin
      for (int k = 0; k < N; k++) mValid[k] = 1'b0;
      for (int k = 0; k < 3; k++) begin pTk[k] = 1'b0; pTgt[k] = '0; end
    end else begin
      if (bm && ps) begin
        mValid[idxOf(pm)] = 1'b1;
        mTag[idxOf(pm)]   = tagOf(pm);
        mTgt[idxOf(pm)]   = bta[31:2];
      end
      pTk[2] = pTk[1]; pTgt[2] = pTgt[1];
      if (fl) begin pTk[1] = 1'b0; pTgt[1] = '0; end
      else    begin pTk[1] = pTk[0]; pTgt[1] = pTgt[0]; end
      if (!st) begin pTk[0] = e.tk; pTgt[0] = tgt; end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] poolPc();
    logic [31:0] v;
    if ($urandom_range(0, 7) == 0) begin
      v = $urandom();
      v[1:0] = 2'b00;
    end else begin
      v = 32'h0040_0000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
    end
    return v;
  endfunction

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h0040_0000, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 1, 0, 0, 0, 0, 0, 0, 1);
    // install 0x00400010 -> 0x00400100, then hit
    cyc(0, 32'h0040_0040, 0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0100, 1);
    cyc(0, 32'h0040_0010, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 1, 32'h0040_0010, 0, 32'h0040_0100, 1);
    cyc(0, 32'h0040_0010, 1, 0, 0, 0, 0, 0, 0, 1);
    // same index, different tag replaces the entry
    cyc(0, 32'h0040_0000, 0, 0, 0, 1, 32'h0040_0410, 1, 32'h0040_0800, 1);
    cyc(0, 32'h0040_0010, 1, 0, 0, 0, 0, 0, 0, 1);
    // predicted taken to 0x00400100, resolved taken to 0x00400200
    cyc(0, 32'h0040_0000, 0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0100, 1);
    cyc(0, 32'h0040_0010, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0200, 1);
    // same again with flushE in the D cycle
    cyc(0, 32'h0040_0000, 0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0100, 1);
    cyc(0, 32'h0040_0010, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 1, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0000, 0, 0, 0, 1, 32'h0040_0010, 1, 32'h0040_0100, 1);
    // same-cycle update and lookup, then wraparound of pcF+4
    cyc(0, 32'h0040_0020, 1, 0, 0, 1, 32'h0040_0020, 1, 32'h0040_0300, 1);
    cyc(0, 32'h0040_0020, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0, 1);
    // reset wins over a concurrent update and stall
    cyc(1, 32'h0040_0020, 1, 1, 0, 1, 32'h0040_0030, 1, 32'h0040_0500, 1);
    cyc(0, 32'h0040_0030, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 32'h0040_0020, 1, 0, 0, 0, 0, 0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] bta;
      bta = 32'h0050_0000 + ($urandom_range(0, 3) << 2);
      cyc($urandom_range(0, 99) == 0, poolPc(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1, poolPc(), $urandom_range(0, 2) != 0, bta, 1);
    end

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (expQ.size() == 0) passed++;
    else $display("FAIL drain: %0d expected responses left, required 0", expQ.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
